mem_arbiter: RTL

Two-requester round-robin arbiter and sequencer in front of the `memory` block. It shares the single memory port between the CPU (requester 0) and a second bus master such as a UART loader or DMA (requester 1). It converts a simple req/ack handshake into the memory's `ce`/`w`/`r`/`oe` sequencing, including the one-cycle registered read latency. It sits between the masters and `memory`; the masters never drive `memory` directly.

---
 rtl/mem_arb_pkg.sv | 11 +
 rtl/mem_arbiter_rr_pick2.sv | 12 +
 rtl/mem_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and requester IDs for mem_arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDATA  = 2'd2,
        DONE   = 2'd3
    } state_e;
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_AUX = 1'b1;
endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin pick favouring the requester not granted last
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_gnt_i,
    output logic       valid_o,
    output logic       gnt_o
);
    assign valid_o = |req_i;
    assign gnt_o   = &req_i ? ~last_gnt_i : (req_i[REQ_AUX] ? REQ_AUX : REQ_CPU);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter sequencing a single registered-read memory port
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_in_data,
    output logic              mem_ce,
    output logic              mem_w,
    output logic              mem_r,
    output logic              mem_oe,
    input  logic [DATA_W-1:0] mem_out_data,
    output logic              busy,
    output logic              gnt_id
);
    state_e            state_q, state_d;
    logic              last_gnt_q, gnt_id_q, we_q;
    logic              pick_valid, pick_id, grant, win_we;
    logic [ADDR_W-1:0] win_addr, mem_addr_q;
    logic [DATA_W-1:0] win_wdata, mem_in_data_q, m0_rdata_q, m1_rdata_q;
    logic              mem_ce_q, mem_w_q, mem_r_q, mem_oe_q, m0_ack_q, m1_ack_q, busy_q;

    rr_pick2 u_pick (
        .req_i      ({m1_req, m0_req}),
        .last_gnt_i (last_gnt_q),
        .valid_o    (pick_valid),
        .gnt_o      (pick_id)
    );

    assign grant     = (state_q == IDLE) && pick_valid;
    assign win_we    = pick_id ? m1_we : m0_we;
    assign win_addr  = pick_id ? m1_addr : m0_addr;
    assign win_wdata = pick_id ? m1_wdata : m0_wdata;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = pick_valid ? ACCESS : IDLE;
            ACCESS:  state_d = we_q ? DONE : RDATA;
            RDATA:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are computed from the next state so every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_gnt_q    <= REQ_AUX;
            gnt_id_q      <= REQ_CPU;
            we_q          <= 1'b0;
            mem_addr_q    <= '0;
            mem_in_data_q <= '0;
            m0_rdata_q    <= '0;
            m1_rdata_q    <= '0;
            mem_ce_q      <= 1'b0;
            mem_w_q       <= 1'b0;
            mem_r_q       <= 1'b0;
            mem_oe_q      <= 1'b0;
            m0_ack_q      <= 1'b0;
            m1_ack_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                gnt_id_q      <= pick_id;
                last_gnt_q    <= pick_id;
                we_q          <= win_we;
                mem_addr_q    <= win_addr;
                mem_in_data_q <= win_wdata;
            end
            if (state_q == RDATA && gnt_id_q == REQ_CPU) m0_rdata_q <= mem_out_data;
            if (state_q == RDATA && gnt_id_q == REQ_AUX) m1_rdata_q <= mem_out_data;
            mem_ce_q <= (state_d == ACCESS) || (state_d == RDATA);
            mem_w_q  <= grant && win_we;
            mem_r_q  <= grant && !win_we;
            mem_oe_q <= state_d == RDATA;
            m0_ack_q <= (state_d == DONE) && (gnt_id_q == REQ_CPU);
            m1_ack_q <= (state_d == DONE) && (gnt_id_q == REQ_AUX);
            busy_q   <= state_d != IDLE;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_in_data = mem_in_data_q;
    assign mem_ce      = mem_ce_q;
    assign mem_w       = mem_w_q;
    assign mem_r       = mem_r_q;
    assign mem_oe      = mem_oe_q;
    assign m0_ack      = m0_ack_q;
    assign m1_ack      = m1_ack_q;
    assign m0_rdata    = m0_rdata_q;
    assign m1_rdata    = m1_rdata_q;
    assign busy        = busy_q;
    assign gnt_id      = gnt_id_q;
endmodule
